// File: rtl/clk_div_cfg_ctrl.sv
// Configuration front-end for the integer clock divider: validates ratio/bypass
// requests and applies them only on a divided-period boundary. Optional macro: CFG_LOCK_EN.
module clk_div_cfg_ctrl #(
   parameter logic [3:0] DEFAULT_RATIO = 4'd2,
   parameter logic       DEFAULT_EN    = 1'b1
) (
   input  logic       I_ref_clk,
   input  logic       I_rst_n,
   input  logic       I_cfg_valid,
   input  logic [3:0] I_cfg_ratio,
   input  logic       I_cfg_bypass,
`ifdef CFG_LOCK_EN
   input  logic       I_cfg_lock,
`endif
   output logic       O_cfg_ready,
   output logic [3:0] O_div_ratio,
   output logic       O_clk_en,
   output logic       O_cfg_err,
   output logic       O_period_tick,
   output logic [3:0] O_phase
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      APPLY = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] ratio_q, ratio_d;
   logic       en_q, en_d;
   logic [3:0] phase_q, phase_d;
   logic       err_q, err_d;
   logic [3:0] pend_ratio_q, pend_ratio_d;
   logic       pend_en_q, pend_en_d;
   logic       boundary;
   logic       xfer;

`ifdef CFG_LOCK_EN
   assign O_cfg_ready = (state_q == IDLE) && !I_cfg_lock;
`else
   assign O_cfg_ready = (state_q == IDLE);
`endif

   assign xfer     = I_cfg_valid && O_cfg_ready;
   assign boundary = (phase_q == ratio_q);

   // NOTE: every _d gets a default at the top so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      ratio_d      = ratio_q;
      en_d         = en_q;
      pend_ratio_d = pend_ratio_q;
      pend_en_d    = pend_en_q;
      err_d        = 1'b0;
      phase_d      = (phase_q < ratio_q) ? phase_q + 4'd1 : 4'd1;

      case (state_q)
         IDLE: begin
            if (xfer) begin
               if (!I_cfg_bypass && (I_cfg_ratio < 4'd2)) begin
                  err_d = 1'b1;
               end else begin
                  // A bypass request keeps the current ratio for when divide mode returns.
                  pend_ratio_d = I_cfg_bypass ? ratio_q : I_cfg_ratio;
                  pend_en_d    = !I_cfg_bypass;
                  state_d      = PEND;
               end
            end
         end
         PEND: begin
            // Bypass has no divided period to protect, so apply without waiting.
            if (!en_q || boundary) begin
               ratio_d = pend_ratio_q;
               en_d    = pend_en_q;
               phase_d = 4'd1;
               state_d = APPLY;
            end
         end
         APPLY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state flops use non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q      <= IDLE;
         ratio_q      <= DEFAULT_RATIO;
         en_q         <= DEFAULT_EN;
         phase_q      <= 4'd1;
         err_q        <= 1'b0;
         pend_ratio_q <= DEFAULT_RATIO;
         pend_en_q    <= DEFAULT_EN;
      end else begin
         state_q      <= state_d;
         ratio_q      <= ratio_d;
         en_q         <= en_d;
         phase_q      <= phase_d;
         err_q        <= err_d;
         pend_ratio_q <= pend_ratio_d;
         pend_en_q    <= pend_en_d;
      end
   end

   assign O_div_ratio   = ratio_q;
   assign O_clk_en      = en_q;
   assign O_phase       = phase_q;
   assign O_cfg_err     = err_q;
   assign O_period_tick = boundary;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl: directed vector table, hand sequences,
// and random traffic against a schedule-based reference model. Honours CFG_LOCK_EN.
module tb_clk_div_cfg_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [3:0] cfg_ratio = 4'd0;
   logic       cfg_bypass = 1'b0;
   logic       cfg_lock = 1'b0;
   logic       cfg_ready;
   logic [3:0] div_ratio;
   logic       clk_en;
   logic       cfg_err;
   logic       period_tick;
   logic [3:0] phase;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clk_div_cfg_ctrl dut (
      .I_ref_clk    (clk),
      .I_rst_n      (rst_n),
      .I_cfg_valid  (cfg_valid),
      .I_cfg_ratio  (cfg_ratio),
      .I_cfg_bypass (cfg_bypass),
`ifdef CFG_LOCK_EN
      .I_cfg_lock   (cfg_lock),
`endif
      .O_cfg_ready  (cfg_ready),
      .O_div_ratio  (div_ratio),
      .O_clk_en     (clk_en),
      .O_cfg_err    (cfg_err),
      .O_period_tick(period_tick),
      .O_phase      (phase)
   );

   // Reference model: a legal transfer schedules its load a computed number of
   // cycles ahead; cd counts down to the load edge (cd==2) and the APPLY cycle (cd==1).
   int         m_cd;
   logic [3:0] m_ratio, m_phase, m_pratio;
   logic       m_en, m_pen, m_err;

   function automatic logic m_ready();
      return (m_cd == 0) && !cfg_lock;
   endfunction

   task automatic model_reset();
      m_cd = 0; m_ratio = 4'd2; m_en = 1'b1; m_phase = 4'd1; m_err = 1'b0;
      m_pratio = 4'd2; m_pen = 1'b1;
   endtask

   task automatic model_edge(input logic xfer, input logic [3:0] r, input logic b);
      int  k;
      logic legal;
      legal = b || (r >= 4'd2);
      m_err = xfer && !legal;
      if (m_cd > 0) begin
         if (m_cd == 2) begin
            m_ratio = m_pratio;
            m_en    = m_pen;
            m_phase = 4'd1;
         end else begin
            m_phase = (m_phase < m_ratio) ? m_phase + 4'd1 : 4'd1;
         end
         m_cd = m_cd - 1;
      end else begin
         if (xfer && legal) begin
            if (!m_en)                k = 1;
            else if (m_phase == m_ratio) k = int'(m_ratio);
            else                      k = int'(m_ratio) - int'(m_phase);
            m_cd     = k + 1;
            m_pratio = b ? m_ratio : r;
            m_pen    = !b;
         end
         m_phase = (m_phase < m_ratio) ? m_phase + 4'd1 : 4'd1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("ready", {31'd0, cfg_ready}, {31'd0, m_ready()});
      check("ratio", {28'd0, div_ratio}, {28'd0, m_ratio});
      check("clk_en", {31'd0, clk_en}, {31'd0, m_en});
      check("phase", {28'd0, phase}, {28'd0, m_phase});
      check("tick", {31'd0, period_tick}, {31'd0, (m_phase == m_ratio)});
      check("err", {31'd0, cfg_err}, {31'd0, m_err});
   endtask

   // One ref cycle: entered and left at a falling edge.
   task automatic step(input logic v, input logic [3:0] r, input logic b);
      logic xfer;
      cfg_valid = v; cfg_ratio = r; cfg_bypass = b;
      #1;
      check_model();
      xfer = v && m_ready();
      @(posedge clk);
      model_edge(xfer, r, b);
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_ratio", {28'd0, div_ratio}, 32'd2);
      check("rst_en", {31'd0, clk_en}, 32'd1);
      check("rst_phase", {28'd0, phase}, 32'd1);
      check("rst_ready", {31'd0, cfg_ready}, {31'd0, !cfg_lock});
      check("rst_err", {31'd0, cfg_err}, 32'd0);
      check("rst_tick", {31'd0, period_tick}, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic       v;
      logic [3:0] r;
      logic       b;
      logic       rdy;
      logic [3:0] ratio;
      logic       en;
      logic [3:0] ph;
      logic       tick;
      logic       err;
   } vec_t;

   vec_t vecs[15];

   initial begin
      int n;
      vecs[0]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 4'd1, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 4'd5, 1'b0, 1'b1, 4'd2, 1'b1, 4'd1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 4'd1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 4'd2, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 4'd3, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 4'd4, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 4'd1, 1'b0, 1'b1, 4'd5, 1'b1, 4'd1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 4'd2, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 4'd3, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 4'd4, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 4'd1, 1'b0, 1'b0};

      model_reset();
      @(negedge clk);
      @(negedge clk);
      do_reset();

      // Defaults, 2->5 change, illegal ratios 1 and 0.
      for (int i = 0; i < 15; i++) begin
         cfg_valid = vecs[i].v; cfg_ratio = vecs[i].r; cfg_bypass = vecs[i].b;
         #1;
         check($sformatf("vec%0d_ready", i), {31'd0, cfg_ready}, {31'd0, vecs[i].rdy});
         check($sformatf("vec%0d_ratio", i), {28'd0, div_ratio}, {28'd0, vecs[i].ratio});
         check($sformatf("vec%0d_en", i), {31'd0, clk_en}, {31'd0, vecs[i].en});
         check($sformatf("vec%0d_phase", i), {28'd0, phase}, {28'd0, vecs[i].ph});
         check($sformatf("vec%0d_tick", i), {31'd0, period_tick}, {31'd0, vecs[i].tick});
         check($sformatf("vec%0d_err", i), {31'd0, cfg_err}, {31'd0, vecs[i].err});
         step(vecs[i].v, vecs[i].r, vecs[i].b);
      end

      // Bypass requested at phase 3 of a ratio-7 period lands after phase 7.
      step(1'b1, 4'd7, 1'b0);
      n = 0;
      while (!(m_cd == 0 && m_ratio == 4'd7 && m_phase == 4'd3) && n < 40) begin
         step(1'b0, 4'd0, 1'b0);
         n++;
      end
      check("reach_r7_ph3", n < 40, 1);
      step(1'b1, 4'd0, 1'b1);
      n = 1;
      while (clk_en && n < 20) begin
         step(1'b0, 4'd0, 1'b0);
         n++;
      end
      check("bypass_latency", n, 5);
      check("bypass_en", {31'd0, clk_en}, 32'd0);
      check("bypass_ratio", {28'd0, div_ratio}, 32'd7);
      step(1'b0, 4'd0, 1'b0);
      step(1'b1, 4'd3, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      check("from_bypass_ratio", {28'd0, div_ratio}, 32'd3);
      check("from_bypass_en", {31'd0, clk_en}, 32'd1);
      step(1'b0, 4'd0, 1'b0);

      // Back-to-back valid: second request held off until the first is applied.
      step(1'b1, 4'd4, 1'b0);
      check("b2b_held_ready", {31'd0, cfg_ready}, 32'd0);
      for (int i = 0; i < 14; i++) step(1'b1, 4'd6, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 4'd0, 1'b0);

      // Reset while a request is pending discards it.
      do_reset();
      step(1'b1, 4'd9, 1'b0);
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 1'b0);
      check("pend_discarded", {28'd0, div_ratio}, 32'd2);

`ifdef CFG_LOCK_EN
      cfg_lock = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 4'd9, 1'b0);
      check("lock_ready", {31'd0, cfg_ready}, 32'd0);
      check("lock_not_taken", {28'd0, div_ratio}, 32'd2);
      cfg_lock = 1'b0;
      n = 0;
      while (m_cd == 0 && n < 5) begin
         step(1'b1, 4'd9, 1'b0);
         n++;
      end
      n = 0;
      while (div_ratio != 4'd9 && n < 30) begin
         step(1'b0, 4'd0, 1'b0);
         n++;
      end
      check("unlock_applied", {28'd0, div_ratio}, 32'd9);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
`ifdef CFG_LOCK_EN
         cfg_lock = ($urandom_range(0, 9) == 0);
`endif
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 4) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_div_cfg_ctrl.md
Name: clk_div_cfg_ctrl

Overview:
Configuration front-end for the integer clock divider. Accepts ratio/bypass requests over a valid/ready handshake, validates them, and drives the divider's enable and ratio inputs. It tracks the divider's period with its own phase counter and changes the outputs only on a period boundary, so the divided clock never sees a truncated or stretched period. Sits directly upstream of the divider in the I_ref_clk domain.

Parameters:
DEFAULT_RATIO, 4'd2, ratio driven on O_div_ratio out of reset (legal range 2..15)
DEFAULT_EN, 1'b1, O_clk_en value out of reset (1 = divide, 0 = bypass)

Ports:
I_ref_clk  input  1  reference clock; same clock as the divider
I_rst_n  input  1  asynchronous active-low reset
I_cfg_valid  input  1  configuration request valid
I_cfg_ratio  input  4  requested divide ratio
I_cfg_bypass  input  1  1 = request bypass (divider passes I_ref_clk); I_cfg_ratio ignored
O_cfg_ready  output  1  request can be accepted this cycle
O_div_ratio  output  4  ratio to divider, registered
O_clk_en  output  1  divider enable, registered; 0 = bypass
O_cfg_err  output  1  one-cycle pulse on rejected request
O_period_tick  output  1  one-cycle pulse on the last ref cycle of each divided period (phase == O_div_ratio)
O_phase  output  4  mirrored divider counter value, 1..O_div_ratio

Behaviour:
- Reset is asynchronous, active-low, on I_rst_n; clock is I_ref_clk.
- Reset values: O_div_ratio=DEFAULT_RATIO, O_clk_en=DEFAULT_EN, O_phase=1, O_cfg_ready=1, O_cfg_err=0, O_period_tick=0, FSM=IDLE.
- Phase counter: on every clock edge, if phase < O_div_ratio then phase+1, else phase=1. This matches the divider counter exactly, including its reset value of 1. The counter runs regardless of O_clk_en.
- Boundary: a cycle in which phase == O_div_ratio. O_period_tick is the combinational decode of boundary.
- Handshake: a request transfers in a cycle where I_cfg_valid && O_cfg_ready. O_cfg_ready = (state == IDLE). Once a request is accepted, later requests are held off until it is applied.
- Validation happens on the transfer cycle:
  - Bypass=0 with ratio 0 or 1 is illegal. O_cfg_err pulses on the next cycle, the state stays IDLE, and the outputs are unchanged.
  - A legal request is captured into a pending register. The FSM moves to PEND.
- FSM states are IDLE, PEND, and APPLY:
  - IDLE -> PEND on a legal transfer.
  - PEND -> APPLY on the first boundary cycle strictly after the transfer cycle. If the current O_clk_en=0, PEND -> APPLY on the next cycle with no wait, because bypass has no period to protect.
  - APPLY (one cycle): O_div_ratio and O_clk_en load from the pending register. The phase counter is forced to 1 in the same edge. Then APPLY -> IDLE.
- Latency from transfer to new outputs:
  - Divide mode: ≤ O_div_ratio+2 cycles.
  - Bypass mode: exactly 2 cycles.
- Bypass request: the new O_clk_en=0 and O_div_ratio keeps its previous value.
- A request identical to the current settings still goes through the full PEND/APPLY sequence. It produces no error.
- If the boundary coincides with the transfer cycle, the block waits for the next boundary. It does not apply early.
- Reset mid-PEND or mid-APPLY: the pending request is discarded and all outputs return to their reset values.
- Width rules: compare unsigned 4-bit values; no arithmetic wider than 4 bits.

Optional Feature:
CFG_LOCK_EN
- Defined: adds input I_cfg_lock (1 bit). While I_cfg_lock=1, O_cfg_ready=0. A request already in PEND/APPLY still completes.
- Undefined: no I_cfg_lock port, and O_cfg_ready depends only on FSM state.

Test Plan:
1. Reset with defaults: O_div_ratio=2, O_clk_en=1, O_phase=1, ready=1. Then O_phase toggles 1,2,1,2 and O_period_tick is high on phase 2.
2. Ratio change 2->5 at phase 1: O_div_ratio becomes 5 the cycle after the next phase-2 cycle. O_phase restarts at 1 and counts 1..5. There is no stray tick.
3. Bypass request while ratio=7 at phase 3: applied after phase 7. O_clk_en=0 and O_div_ratio stays 7. A following ratio-3 request applies 2 cycles after its transfer.
4. Illegal ratio 1 or 0: O_cfg_err pulses for exactly one cycle. The outputs do not change and ready stays 1.
5. Back-to-back valid: the second request is held with ready=0 until APPLY completes, then transfers. Assert I_rst_n low while in PEND: outputs return to defaults and the pending ratio is never applied.
6. With CFG_LOCK_EN defined: I_cfg_lock=1 holds ready=0 and a ratio-9 request is not taken. Release the lock and the request transfers and applies at the next boundary.
